// File: rtl/spinn_aer_if_cfg_pkg.sv
// Shared definitions for the SpiNNaker AER interface configuration block:
// control-packet field offsets, opcode values and FSM state encoding.
package spinn_aer_if_cfg_pkg;

    // Control packet field layout
    localparam int GO_BIT       = 8;
    localparam int OPC_LSB      = 9;
    localparam int OPC_BITS     = 3;
    localparam int KEY_LSB      = 8;
    localparam int KEY_BITS     = 32;
    localparam int PAYLOAD_LSB  = 40;
    localparam int PAYLOAD_BITS = 32;

    // Opcodes carried in the key field
    localparam logic [OPC_BITS-1:0] OPC_GO       = 3'd0;
    localparam logic [OPC_BITS-1:0] OPC_SET_MODE = 3'd1;
    localparam logic [OPC_BITS-1:0] OPC_SET_KEY  = 3'd2;
    localparam logic [OPC_BITS-1:0] OPC_OVERRIDE = 3'd3;

    // Configuration update sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Opcodes above OVERRIDE have no function and are only counted
    function automatic logic opc_is_bad(input logic [OPC_BITS-1:0] opc);
        return (opc > OPC_OVERRIDE);
    endfunction

endpackage

// File: rtl/spinn_aer_if_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous board switches.
module spinn_aer_if_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give metastability time to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spinn_aer_if_cfg.sv
// SpiNNaker AER interface configuration block. Control packets select the
// output mode, virtual key and forwarding enable; mode/key changes are
// applied only after event forwarding has been quiet for a drain period.
module spinn_aer_if_cfg
    import spinn_aer_if_cfg_pkg::*;
#(
    parameter int                   PKT_BITS     = 72,
    parameter int                   MODE_BITS    = 3,
    parameter int                   VKEY_BITS    = 16,
    parameter int                   VKS_BITS     = 1,
    parameter int                   DRAIN_CYCLES = 16,
    parameter bit                   INIT_GO      = 1'b1,
    parameter logic [MODE_BITS-1:0] DEF_MODE     = '0,
    parameter logic [VKEY_BITS-1:0] DEF_KEY      = 16'h0200,
    parameter logic [VKEY_BITS-1:0] ALT_KEY      = 16'hFEFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PKT_BITS-1:0]  cpkt_data,
    input  logic                 cpkt_vld,
    output logic                 cpkt_rdy,
    input  logic [MODE_BITS-1:0] msel,
    input  logic [VKS_BITS-1:0]  vksel,
    output logic [MODE_BITS-1:0] vmode,
    output logic [VKEY_BITS-1:0] vkey,
    output logic                 go,
    output logic [7:0]           bad_cnt
);

    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

    logic [MODE_BITS-1:0] msel_sync;
    logic [VKS_BITS-1:0]  vksel_sync;

    logic [OPC_BITS-1:0]  opc;
    logic                 go_bit;
    logic [VKEY_BITS-1:0] arg;
    logic                 accept;
    logic                 unused_pkt_bits;

    logic                 sw_ovr;
    logic [MODE_BITS-1:0] sw_mode;
    logic [VKEY_BITS-1:0] sw_key;
    logic [MODE_BITS-1:0] tgt_mode;
    logic [VKEY_BITS-1:0] tgt_key;
    logic                 tgt_diff;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           drain_cnt;
    logic                 rdy_nxt;
    logic                 drain_load;
    logic                 commit_en;

    logic                 go_save;
    logic                 go_saved;

    spinn_aer_if_sync #(.WIDTH(MODE_BITS)) u_msel_sync (
        .clk (clk),
        .rst (rst),
        .d   (msel),
        .q   (msel_sync)
    );

    spinn_aer_if_sync #(.WIDTH(VKS_BITS)) u_vksel_sync (
        .clk (clk),
        .rst (rst),
        .d   (vksel),
        .q   (vksel_sync)
    );

    assign opc    = cpkt_data[OPC_LSB +: OPC_BITS];
    assign go_bit = cpkt_data[GO_BIT];
    assign arg    = cpkt_data[PAYLOAD_LSB +: VKEY_BITS];
    assign accept = cpkt_vld & cpkt_rdy;

    assign unused_pkt_bits = ^{cpkt_data[PKT_BITS-1:PAYLOAD_LSB+VKEY_BITS],
                               cpkt_data[PAYLOAD_LSB-1:OPC_LSB+OPC_BITS],
                               cpkt_data[GO_BIT-1:0]};

    // Target configuration: switches unless software override is enabled
    always_comb begin
        tgt_mode = msel_sync;
        tgt_key  = (vksel_sync == VKS_BITS'(1)) ? ALT_KEY : DEF_KEY;
        if (sw_ovr) begin
            tgt_mode = sw_mode;
            tgt_key  = sw_key;
        end
        tgt_diff = (tgt_mode != vmode) || (tgt_key != vkey);
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: drain only when events are flowing, commit directly otherwise
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (tgt_diff) begin
                    state_nxt = go ? ST_DRAIN : ST_COMMIT;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt <= 8'd1) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer control strobes derived from the current and next state
    always_comb begin
        rdy_nxt    = (state_nxt == ST_IDLE);
        drain_load = (state == ST_IDLE) && (state_nxt == ST_DRAIN);
        commit_en  = (state == ST_COMMIT);
    end

    // Ready is registered from the next state so it never depends on cpkt_vld
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpkt_rdy <= 1'b0;
        end else begin
            cpkt_rdy <= rdy_nxt;
        end
    end

    // Drain counter: loaded on entry to DRAIN, counts the quiet cycles down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= 8'd0;
        end else if (drain_load) begin
            drain_cnt <= DRAIN_INIT;
        end else if ((state == ST_DRAIN) && (drain_cnt != 8'd0)) begin
            drain_cnt <= drain_cnt - 8'd1;
        end
    end

    // Forwarding enable: forced low for a drain, restored at commit; a GO
    // packet arriving as the drain starts is redirected into the saved value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go       <= INIT_GO;
            go_save  <= 1'b0;
            go_saved <= 1'b0;
        end else begin
            if (drain_load) begin
                go       <= 1'b0;
                go_save  <= go;
                go_saved <= 1'b1;
            end
            if (accept && (opc == OPC_GO)) begin
                if (drain_load) begin
                    go_save <= go_bit;
                end else begin
                    go <= go_bit;
                end
            end
            if (commit_en && go_saved) begin
                go       <= go_save;
                go_saved <= 1'b0;
            end
        end
    end

    // Software-staged mode, key and override selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_ovr  <= 1'b0;
            sw_mode <= DEF_MODE;
            sw_key  <= DEF_KEY;
        end else if (accept) begin
            case (opc)
                OPC_SET_MODE: sw_mode <= arg[MODE_BITS-1:0];
                OPC_SET_KEY:  sw_key  <= arg;
                OPC_OVERRIDE: sw_ovr  <= go_bit;
                default:      ;
            endcase
        end
    end

    // Active configuration changes only in COMMIT, taking the latest target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vmode <= DEF_MODE;
            vkey  <= DEF_KEY;
        end else if (commit_en) begin
            vmode <= tgt_mode;
            vkey  <= tgt_key;
        end
    end

    // Saturating count of packets with unknown opcodes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_cnt <= 8'd0;
        end else if (accept && opc_is_bad(opc) && (bad_cnt != 8'hFF)) begin
            bad_cnt <= bad_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_spinn_aer_if_cfg.sv
// Directed self-checking bench for spinn_aer_if_cfg with default parameters.
module tb_spinn_aer_if_cfg;

    localparam int DRAIN = 16;

    logic        clk;
    logic        rst;
    logic [71:0] cpkt_data;
    logic        cpkt_vld;
    logic        cpkt_rdy;
    logic [2:0]  msel;
    logic [0:0]  vksel;
    logic [2:0]  vmode;
    logic [15:0] vkey;
    logic        go;
    logic [7:0]  bad_cnt;

    int checks;
    int errors;

    spinn_aer_if_cfg #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpkt_data (cpkt_data),
        .cpkt_vld  (cpkt_vld),
        .cpkt_rdy  (cpkt_rdy),
        .msel      (msel),
        .vksel     (vksel),
        .vmode     (vmode),
        .vkey      (vkey),
        .go        (go),
        .bad_cnt   (bad_cnt)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset and return at the negedge after the first post-reset posedge
    task automatic apply_reset();
        rst      = 1'b1;
        cpkt_vld = 1'b0;
        cpkt_data = '0;
        msel     = 3'd0;
        vksel    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Present one packet from a negedge, returns at the negedge after acceptance
    task automatic send_pkt(input logic [2:0] opc, input logic gb, input logic [15:0] arg);
        int waited;
        cpkt_data        = '0;
        cpkt_data[71:56] = 16'hA5C3;
        cpkt_data[39:12] = 28'h5A5A5A5;
        cpkt_data[11:9]  = opc;
        cpkt_data[8]     = gb;
        cpkt_data[55:40] = arg;
        cpkt_vld         = 1'b1;
        waited           = 0;
        while ((cpkt_rdy !== 1'b1) && (waited < 100)) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cpkt_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_timeout: rdy=%b required 1 within 100 cycles", cpkt_rdy);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        cpkt_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpkt_vld = 1'b0; cpkt_data = '0; msel = 3'd0; vksel = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL reset_go: got %b required 1", go); end
        checks++; if (vmode !== 3'd0) begin errors++; $display("[TB] FAIL reset_vmode: got %0d required 0", vmode); end
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL reset_vkey: got %h required 0200", vkey); end
        checks++; if (cpkt_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy: got %b required 0", cpkt_rdy); end
        checks++; if (bad_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_bad_cnt: got %0d required 0", bad_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (cpkt_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rdy_at_release: got %b required 0", cpkt_rdy); end
        @(negedge clk);
        checks++; if (cpkt_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rdy_after_release: got %b required 1", cpkt_rdy); end
    endtask

    task automatic test_go();
        apply_reset();
        send_pkt(3'd0, 1'b0, 16'h0000);
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL go_clear: got %b required 0", go); end
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL go_clear_vkey: got %h required 0200", vkey); end
        send_pkt(3'd0, 1'b1, 16'h0000);
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL go_set: got %b required 1", go); end
        checks++; if (vmode !== 3'd0) begin errors++; $display("[TB] FAIL go_set_vmode: got %0d required 0", vmode); end
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL go_set_vkey: got %h required 0200", vkey); end
    endtask

    task automatic test_override_drain();
        apply_reset();
        send_pkt(3'd3, 1'b1, 16'h0000);
        checks++; if (cpkt_rdy !== 1'b1) begin errors++; $display("[TB] FAIL ovr_no_drain: rdy=%b required 1", cpkt_rdy); end
        send_pkt(3'd2, 1'b0, 16'h1234);
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL key_accept_go: got %b required 1", go); end
        for (int k = 1; k <= DRAIN + 1; k++) begin
            @(negedge clk);
            checks++;
            if ((go !== 1'b0) || (cpkt_rdy !== 1'b0) || (vkey !== 16'h0200)) begin
                errors++;
                $display("[TB] FAIL drain_hold cycle %0d: go=%b rdy=%b vkey=%h required go=0 rdy=0 vkey=0200", k, go, cpkt_rdy, vkey);
            end
        end
        @(negedge clk);
        checks++; if (vkey !== 16'h1234) begin errors++; $display("[TB] FAIL drain_commit_vkey: got %h required 1234", vkey); end
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL drain_restore_go: got %b required 1", go); end
        checks++; if (cpkt_rdy !== 1'b1) begin errors++; $display("[TB] FAIL drain_rdy_back: got %b required 1", cpkt_rdy); end
    endtask

    task automatic test_no_drain_mode();
        apply_reset();
        send_pkt(3'd0, 1'b0, 16'h0000);
        send_pkt(3'd3, 1'b1, 16'h0000);
        send_pkt(3'd1, 1'b0, 16'hFFF5);
        checks++; if (vmode !== 3'd0) begin errors++; $display("[TB] FAIL mode_lat0: got %0d required 0", vmode); end
        @(negedge clk);
        checks++; if (vmode !== 3'd0) begin errors++; $display("[TB] FAIL mode_lat1: got %0d required 0", vmode); end
        checks++; if (cpkt_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mode_commit_rdy: got %b required 0", cpkt_rdy); end
        @(negedge clk);
        checks++; if (vmode !== 3'd5) begin errors++; $display("[TB] FAIL mode_lat2: got %0d required 5", vmode); end
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL mode_go: got %b required 0", go); end
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL mode_vkey: got %h required 0200", vkey); end
    endtask

    task automatic test_switch_key();
        int low_cycles;
        apply_reset();
        send_pkt(3'd0, 1'b0, 16'h0000);
        vksel = 1'b1;
        low_cycles = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (cpkt_rdy === 1'b0) low_cycles++;
            checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL sw_go cycle %0d: got %b required 0", k, go); end
        end
        checks++; if (vkey !== 16'hFEFF) begin errors++; $display("[TB] FAIL sw_vkey: got %h required feff", vkey); end
        repeat (4) begin
            @(negedge clk);
            if (cpkt_rdy === 1'b0) low_cycles++;
        end
        checks++; if (low_cycles !== 1) begin errors++; $display("[TB] FAIL sw_no_drain: busy cycles %0d required 1", low_cycles); end
    endtask

    task automatic test_switch_during_drain();
        int busy;
        apply_reset();
        vksel = 1'b1;
        repeat (8) @(negedge clk);
        msel = 3'd3;
        repeat (11) @(negedge clk);
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL swd_in_commit: vkey=%h required 0200", vkey); end
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL swd_go_low: got %b required 0", go); end
        @(negedge clk);
        checks++; if (vkey !== 16'hFEFF) begin errors++; $display("[TB] FAIL swd_vkey: got %h required feff", vkey); end
        checks++; if (vmode !== 3'd3) begin errors++; $display("[TB] FAIL swd_vmode: got %0d required 3", vmode); end
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL swd_go: got %b required 1", go); end
        busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpkt_rdy !== 1'b1) busy++;
        end
        checks++; if (busy !== 0) begin errors++; $display("[TB] FAIL swd_second_drain: busy cycles %0d required 0", busy); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_pkt(3'd3, 1'b1, 16'h0000);
        send_pkt(3'd2, 1'b0, 16'h1234);
        send_pkt(3'd0, 1'b0, 16'h0000);
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL b2b_go_forced: got %b required 0", go); end
        checks++; if (cpkt_rdy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rdy: got %b required 0", cpkt_rdy); end
        repeat (16) @(negedge clk);
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL b2b_early: vkey=%h required 0200", vkey); end
        @(negedge clk);
        checks++; if (vkey !== 16'h1234) begin errors++; $display("[TB] FAIL b2b_vkey: got %h required 1234", vkey); end
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL b2b_go_saved: got %b required 0", go); end
    endtask

    task automatic test_bad_cnt();
        apply_reset();
        repeat (4) send_pkt(3'd5, 1'b1, 16'h1234);
        checks++; if (bad_cnt !== 8'd4) begin errors++; $display("[TB] FAIL bad_cnt_4: got %0d required 4", bad_cnt); end
        repeat (256) send_pkt(3'd5, 1'b0, 16'h0007);
        checks++; if (bad_cnt !== 8'd255) begin errors++; $display("[TB] FAIL bad_cnt_sat: got %0d required 255", bad_cnt); end
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL bad_go: got %b required 1", go); end
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL bad_vkey: got %h required 0200", vkey); end
        checks++; if (vmode !== 3'd0) begin errors++; $display("[TB] FAIL bad_vmode: got %0d required 0", vmode); end
        checks++; if (cpkt_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bad_rdy: got %b required 1", cpkt_rdy); end
    endtask

    task automatic test_reset_in_drain();
        int bad;
        apply_reset();
        send_pkt(3'd3, 1'b1, 16'h0000);
        send_pkt(3'd2, 1'b0, 16'h1234);
        repeat (12) @(negedge clk);
        checks++; if (go !== 1'b0) begin errors++; $display("[TB] FAIL rid_in_drain: go=%b required 0", go); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (vkey !== 16'h0200) begin errors++; $display("[TB] FAIL rid_vkey: got %h required 0200", vkey); end
        checks++; if (go !== 1'b1) begin errors++; $display("[TB] FAIL rid_go: got %b required 1", go); end
        checks++; if (cpkt_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rid_rdy: got %b required 0", cpkt_rdy); end
        rst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if ((cpkt_rdy !== 1'b1) || (vkey !== 16'h0200) || (go !== 1'b1)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rid_no_commit: %0d disturbed cycles required 0", bad); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cpkt_vld = 1'b0;
        cpkt_data = '0;
        msel = 3'd0;
        vksel = 1'b0;
        @(negedge clk);
        $display("[TB] starting directed tests");
        test_reset();
        test_go();
        test_override_drain();
        test_no_drain_mode();
        test_switch_key();
        test_switch_during_drain();
        test_back_to_back();
        test_bad_cnt();
        test_reset_in_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spinn_aer_if_cfg.md
SPINN_AER_IF_CFG -- requirements
Module: spinn_aer_if_cfg

Interface
REQ-001 Parameter PKT_BITS, default 72, SpiNNaker packet width.
REQ-002 Parameter MODE_BITS, default 3, output-mode selector width.
REQ-003 Parameter VKEY_BITS, default 16, virtual key width.
REQ-004 Parameter VKS_BITS, default 1, key-select input width.
REQ-005 Parameter DRAIN_CYCLES, default 16, range 1..255, go-low quiet time before a staged update commits.
REQ-006 Parameters INIT_GO (default 1), DEF_MODE (default 0), DEF_KEY (default 16'h0200), ALT_KEY (default 16'hFEFF): reset values.
REQ-007 Ports, one clock and one reset; reset is asynchronous and active-high:
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- cpkt_data  in  PKT_BITS  control packet: [39:8] key, [71:40] payload
- cpkt_vld  in  1  packet valid
- cpkt_rdy  out  1  packet accepted when vld&rdy
- msel  in  MODE_BITS  board switch mode, asynchronous
- vksel  in  VKS_BITS  board switch key select, asynchronous
- vmode  out  MODE_BITS  active mode
- vkey  out  VKEY_BITS  active virtual key
- go  out  1  event forwarding enable
- bad_cnt  out  8  count of unknown opcodes, saturating

Function
REQ-008 A packet SHALL be accepted only in the cycle where cpkt_vld=1 and cpkt_rdy=1.
REQ-009 Opcode = cpkt_data[11:9]; go bit = cpkt_data[8]; arg = cpkt_data[40+VKEY_BITS-1:40].
REQ-010 Opcode 0 (GO) SHALL set go to cpkt_data[8] on the next edge, preserving legacy behaviour.
REQ-011 Opcode 1 (SET_MODE) SHALL stage arg[MODE_BITS-1:0] as the new software mode.
REQ-012 Opcode 2 (SET_KEY) SHALL stage arg as the new software key.
REQ-013 Opcode 3 (OVERRIDE) SHALL set sw_ovr to cpkt_data[8]; with sw_ovr=0, mode and key come from the synchronised switches; with sw_ovr=1, they come from the software registers.
REQ-014 Opcodes 4..7 SHALL be ignored functionally and SHALL increment bad_cnt, saturating at 255.
REQ-015 msel and vksel SHALL pass through 2-flop synchronisers. Switch key: vksel_sync==1 gives ALT_KEY; any other value gives DEF_KEY.
REQ-016 FSM states: IDLE, DRAIN, COMMIT.
REQ-017 IDLE: cpkt_rdy=1. When the selected {mode,key} target differs from {vmode,vkey}:
- if go=0: go to COMMIT;
- otherwise: save go into go_save, force go=0, load the drain counter with DRAIN_CYCLES, go to DRAIN.
REQ-018 DRAIN: cpkt_rdy=0. The counter decrements once per cycle; at 0 the FSM SHALL go to COMMIT.
REQ-019 COMMIT (one cycle): cpkt_rdy=0; vmode/vkey load the target; go is restored from go_save if it was saved, otherwise unchanged; next state IDLE.
REQ-020 vmode/vkey SHALL change only in COMMIT. Latency from packet acceptance with go=1 to new vmode/vkey is DRAIN_CYCLES+2 cycles; with go=0 it is 2 cycles.
REQ-021 A switch change during DRAIN SHALL be captured by re-evaluating the target in COMMIT (the latest value wins). No second drain occurs.
REQ-022 cpkt_rdy SHALL be a registered output (no combinational path from cpkt_vld).
REQ-023 A GO packet accepted in the same cycle the FSM leaves IDLE SHALL update go_save, not go, so that the commanded value takes effect at COMMIT.

Reset
REQ-024 During reset:
- go = INIT_GO
- vmode = DEF_MODE
- vkey = DEF_KEY
- sw_ovr = 0
- software mode/key = DEF_MODE/DEF_KEY
- bad_cnt = 0
- state = IDLE
- cpkt_rdy = 0
REQ-025 cpkt_rdy SHALL rise 1 cycle after rst deasserts.
REQ-026 Reset asserted during DRAIN SHALL abort the FSM to IDLE with reset values; no commit occurs.

Structure
REQ-027 A shared package/header SHALL hold the opcode constants, FSM state encodings and the packet field offsets.
REQ-028 One sub-module, spinn_aer_if_sync (parametrised-width 2-flop synchroniser), SHALL be used for msel and vksel.

Verification
REQ-029 Reset with INIT_GO=1: after reset go=1, vmode=0, vkey=16'h0200, cpkt_rdy=1 one cycle after release.
REQ-030 GO packet with bit8=0, then a GO packet with bit8=1: go=0 next edge, then go=1 next edge. vkey/vmode stay unchanged.
REQ-031 Set go=1. Send OVERRIDE=1, then SET_KEY arg=16'h1234. Required:
- go=0 for 16 cycles, then vkey=16'h1234 and go=1 in COMMIT+1;
- cpkt_rdy=0 throughout.
REQ-032 Set go=0. Toggle vksel 0->1. Required: vkey=16'hFEFF within 4 cycles; go stays 0; no DRAIN state.
REQ-033 Send 260 opcode-5 packets. Required: bad_cnt=255 (saturated); outputs unchanged.
REQ-034 Assert rst at DRAIN count 5. Required: state IDLE, vkey=DEF_KEY, go=INIT_GO, no commit afterwards.
